// File: rtl/wb_report_queue_if.sv
// wb_report_queue_if
// Bundles the writeback snoop inputs, the peripheral-side valid/ready report
// stream and the occupancy status of wb_report_queue.
//   slave  : used by the queue (consumes writeback, produces reports/status)
//   master : used by the environment driving writeback and consuming reports
// Signals:
//   write, write_reg[4:0], write_data   writeback snoop
//   to_peripheral[1:0], to_peripheral_reg[4:0], to_peripheral_data,
//   to_peripheral_valid, to_peripheral_ready     head-of-queue report stream
//   count, full                         occupancy status
//   dropped_count[15:0]                 only when WB_REPORT_LOSS_EN is defined
//   report                              simulation statistics dump trigger
interface wb_report_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  write;
  logic [4:0]            write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [1:0]            to_peripheral;
  logic [4:0]            to_peripheral_reg;
  logic [DATA_WIDTH-1:0] to_peripheral_data;
  logic                  to_peripheral_valid;
  logic                  to_peripheral_ready;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  report;
`ifdef WB_REPORT_LOSS_EN
  logic [15:0]           dropped_count;
`endif

  modport slave (
    input  write, write_reg, write_data, to_peripheral_ready, report,
    output to_peripheral, to_peripheral_reg, to_peripheral_data,
           to_peripheral_valid, count, full
`ifdef WB_REPORT_LOSS_EN
    , output dropped_count
`endif
  );

  modport master (
    output write, write_reg, write_data, to_peripheral_ready, report,
    input  to_peripheral, to_peripheral_reg, to_peripheral_data,
           to_peripheral_valid, count, full
`ifdef WB_REPORT_LOSS_EN
    , input dropped_count
`endif
  );
endinterface

// File: rtl/wb_report_queue.sv
// wb_report_queue
// Snoops the writeback port of one core, keeps writes whose destination is
// selected by REG_MASK (never x0), and queues them in a DEPTH-entry show-ahead
// FIFO drained over a valid/ready handshake. Backpressure never stalls the
// core: a write arriving at a full FIFO that is not popping the same cycle
// is dropped.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; flushes the queue
//   bus    wb_report_queue_if.slave (writeback snoop, report stream, status)
// Optional feature macro WB_REPORT_LOSS_EN: adds a saturating 16-bit
// dropped_count and marks the first report after any loss with code 2'b01.
// Without it, drops are silent and every report carries code 2'b00.
module wb_report_queue #(
  parameter int          CORE       = 0,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] REG_MASK   = 32'h03FC0200
) (
  input logic              clock,
  input logic              reset,
  wb_report_queue_if.slave bus
);
  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic [1:0]            code_mem [DEPTH];
  logic [4:0]            reg_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  match;
  logic                  has_head;
  logic                  is_full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [1:0]            push_code;

  always_comb begin
    match    = bus.write && (bus.write_reg != 5'd0) && REG_MASK[bus.write_reg];
    has_head = (occ != '0);
    is_full  = (occ == FULL_COUNT);
    pop      = has_head && bus.to_peripheral_ready;
    // A full queue still accepts when its head leaves in the same cycle.
    push     = match && (!is_full || pop);
    drop     = match && is_full && !pop;
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
    end
  end

  // Entry storage: data path only, no reset
  always_ff @(posedge clock) begin
    if (push) begin
      code_mem[wr_ptr] <= push_code;
      reg_mem[wr_ptr]  <= bus.write_reg;
      data_mem[wr_ptr] <= bus.write_data;
    end
  end

  // Head fields are forced to zero while empty so the outputs read 0 after
  // reset without having to clear the storage array.
  assign bus.to_peripheral_valid = has_head;
  assign bus.to_peripheral       = has_head ? code_mem[rd_ptr] : 2'b00;
  assign bus.to_peripheral_reg   = has_head ? reg_mem[rd_ptr]  : 5'd0;
  assign bus.to_peripheral_data  = has_head ? data_mem[rd_ptr] : '0;
  assign bus.count               = occ;
  assign bus.full                = is_full;

`ifdef WB_REPORT_LOSS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        loss;
  logic [15:0] drops;

  // Loss tracking: a drop and a push are mutually exclusive in one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss  <= 1'b0;
      drops <= 16'd0;
    end else if (drop) begin
      loss  <= 1'b1;
      drops <= sat_inc16(drops);
    end else if (push) begin
      loss  <= 1'b0;
    end
  end

  assign push_code         = loss ? 2'b01 : 2'b00;
  assign bus.dropped_count = drops;
`else
  assign push_code = 2'b00;
`endif

`ifndef SYNTHESIS
  logic [31:0] stat_push;
  logic [31:0] stat_pop;
  logic [31:0] stat_drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_push <= 32'd0;
      stat_pop  <= 32'd0;
      stat_drop <= 32'd0;
    end else begin
      if (push) begin
        stat_push <= stat_push + 32'd1;
        $display(" Core [%d] Register [%d] Value = %d", CORE, bus.write_reg, bus.write_data);
      end
      if (pop)  stat_pop  <= stat_pop + 32'd1;
      if (drop) stat_drop <= stat_drop + 32'd1;
    end
    if (bus.report)
      $display(" Core [%0d] pushes = %0d pops = %0d drops = %0d", CORE, stat_push, stat_pop, stat_drop);
  end
`endif
endmodule

// File: tb/tb_wb_report_queue.sv
// tb_wb_report_queue
// Drives wb_report_queue through directed scenarios followed by randomized
// writeback/backpressure/reset traffic. A queue-based model of the report
// stream is compared against the DUT outputs on every falling edge, and
// directed scenarios add hand-computed literal expectations.
module tb_wb_report_queue;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MASK  = 32'h03FC0200;

  typedef struct packed {
    logic [1:0]  code;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic clock;
  logic reset;
  wb_report_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  wb_report_queue #(
    .CORE(0), .DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_MASK(MASK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  bit   live   = 1'b0;
  ent_t q[$];
  int   m_drops = 0;
  bit   m_loss  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: update on each rising edge from the sampled inputs.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_drops = 0;
      m_loss  = 1'b0;
    end else begin
      int   sz;
      bit   m;
      bit   p;
      ent_t e;
      sz = q.size();
      m  = bus.write && (bus.write_reg != 5'd0) && MASK[bus.write_reg];
      p  = (sz > 0) && bus.to_peripheral_ready;
      if (p) void'(q.pop_front());
      if (m && (sz < DEPTH || p)) begin
`ifdef WB_REPORT_LOSS_EN
        e.code = m_loss ? 2'b01 : 2'b00;
`else
        e.code = 2'b00;
`endif
        e.r = bus.write_reg;
        e.d = bus.write_data;
        q.push_back(e);
        m_loss = 1'b0;
      end else if (m) begin
        if (m_drops < 65535) m_drops++;
        m_loss = 1'b1;
      end
    end
  end

  // Compare process: outputs are registered, so falling edge is stable.
  always @(negedge clock) begin
    if (live) begin
      chk("cmp_valid", 64'(bus.to_peripheral_valid), 64'(q.size() != 0));
      chk("cmp_count", 64'(bus.count), 64'(q.size()));
      chk("cmp_full", 64'(bus.full), 64'(q.size() == DEPTH));
      if (q.size() != 0) begin
        chk("cmp_code", 64'(bus.to_peripheral), 64'(q[0].code));
        chk("cmp_reg", 64'(bus.to_peripheral_reg), 64'(q[0].r));
        chk("cmp_data", 64'(bus.to_peripheral_data), 64'(q[0].d));
      end
`ifdef WB_REPORT_LOSS_EN
      chk("cmp_dropped", 64'(bus.dropped_count), 64'(m_drops));
`endif
    end
  end

  // Called at a falling edge (or time 0): applies inputs for one rising edge
  // and returns at the next falling edge.
  task automatic step(input logic rs, input logic w, input logic [4:0] r,
                      input logic [31:0] d, input logic rdy);
    #1;
    reset                   = rs;
    bus.write               = w;
    bus.write_reg           = r;
    bus.write_data          = d;
    bus.to_peripheral_ready = rdy;
    @(negedge clock);
  endtask

  logic [1:0] loss_code;
  int         regs_a[6] = '{22, 23, 24, 25, 9, 18};
  int         skip_r[4] = '{0, 5, 26, 9};
  bit         skip_w[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
`ifdef WB_REPORT_LOSS_EN
    loss_code = 2'b01;
`else
    loss_code = 2'b00;
`endif
    reset = 1'b1;
    bus.write = 1'b0;
    bus.write_reg = 5'd0;
    bus.write_data = '0;
    bus.to_peripheral_ready = 1'b0;
    bus.report = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    live = 1'b1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.to_peripheral_valid), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_code", 64'(bus.to_peripheral), 64'd0);
    chk("rst_reg", 64'(bus.to_peripheral_reg), 64'd0);
    chk("rst_data", 64'(bus.to_peripheral_data), 64'd0);
`ifdef WB_REPORT_LOSS_EN
    chk("rst_dropped", 64'(bus.dropped_count), 64'd0);
`endif

    // Single report with ready held high
    step(0, 1, 18, 32'h12345678, 1);
    chk("single_valid", 64'(bus.to_peripheral_valid), 64'd1);
    chk("single_reg", 64'(bus.to_peripheral_reg), 64'd18);
    chk("single_data", 64'(bus.to_peripheral_data), 64'h12345678);
    chk("single_code", 64'(bus.to_peripheral), 64'd0);
    step(0, 0, 0, 0, 1);
    chk("single_gone", 64'(bus.to_peripheral_valid), 64'd0);

    // Filtered writes
    for (int i = 0; i < 4; i++) begin
      step(0, skip_w[i], 5'(skip_r[i]), 32'hDEAD0000 + 32'(i), 1);
      chk("filter_count", 64'(bus.count), 64'd0);
      chk("filter_valid", 64'(bus.to_peripheral_valid), 64'd0);
    end

    // Overflow with ready low, then in-order drain
    for (int i = 0; i < 5; i++) step(0, 1, 5'(18 + i), 32'(100 + i), 0);
    chk("ovf_count", 64'(bus.count), 64'd4);
    chk("ovf_full", 64'(bus.full), 64'd1);
`ifdef WB_REPORT_LOSS_EN
    chk("ovf_dropped", 64'(bus.dropped_count), 64'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("drain_reg", 64'(bus.to_peripheral_reg), 64'(18 + i));
      chk("drain_data", 64'(bus.to_peripheral_data), 64'(100 + i));
      step(0, 0, 0, 0, 1);
    end
    chk("drain_empty", 64'(bus.count), 64'd0);

    // Refill; the first push after the earlier drop carries the loss code
    for (int i = 0; i < 4; i++) step(0, 1, 5'(18 + i), 32'(200 + i), 0);
    chk("refill_code", 64'(bus.to_peripheral), 64'(loss_code));
    // Full queue with simultaneous push and pop, across pointer wrap
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 5'(regs_a[i]), 32'(300 + i), 1);
      chk("pp_count", 64'(bus.count), 64'd4);
      chk("pp_full", 64'(bus.full), 64'd1);
      if (i == 0) chk("pp_head0", 64'(bus.to_peripheral_reg), 64'd19);
    end
    chk("pp_head_reg", 64'(bus.to_peripheral_reg), 64'd24);
    chk("pp_head_data", 64'(bus.to_peripheral_data), 64'd302);

    // Loss marking: drop, free a slot, push x9=7
    step(0, 1, 9, 1, 0);
`ifdef WB_REPORT_LOSS_EN
    chk("loss_dropped", 64'(bus.dropped_count), 64'd2);
`endif
    step(0, 0, 0, 0, 1);
    chk("loss_free", 64'(bus.count), 64'd3);
    step(0, 1, 9, 7, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 18, 5, 1);
    chk("loss_head_reg", 64'(bus.to_peripheral_reg), 64'd9);
    chk("loss_head_data", 64'(bus.to_peripheral_data), 64'd7);
    chk("loss_head_code", 64'(bus.to_peripheral), 64'(loss_code));
    step(0, 0, 0, 0, 1);
    chk("after_loss_reg", 64'(bus.to_peripheral_reg), 64'd18);
    chk("after_loss_data", 64'(bus.to_peripheral_data), 64'd5);
    chk("after_loss_code", 64'(bus.to_peripheral), 64'd0);

    // Mid-operation reset with a matching write in the reset cycle
    step(0, 1, 19, 1, 0);
    step(0, 1, 20, 2, 0);
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    step(1, 1, 9, 9, 0);
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_valid", 64'(bus.to_peripheral_valid), 64'd0);
    chk("midrst_full", 64'(bus.full), 64'd0);
`ifdef WB_REPORT_LOSS_EN
    chk("midrst_dropped", 64'(bus.dropped_count), 64'd0);
`endif
    step(0, 0, 0, 0, 1);
    chk("postrst_count", 64'(bus.count), 64'd0);

    // Randomized traffic; ready probability varies by phase
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] r;
      logic       w;
      logic       rdy;
      logic       rs;
      int         idx;
      if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(0, 31));
      else begin
        idx = $urandom_range(0, 8);
        r = (idx == 0) ? 5'd9 : 5'(17 + idx);
      end
      w   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < ((i / 250) % 2 == 0 ? 3 : 8));
      rs  = ($urandom_range(0, 199) == 0);
      step(rs, w, r, $urandom, rdy);
    end

    bus.report = 1'b1;
    step(0, 0, 0, 0, 1);
    bus.report = 1'b0;
    step(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
